// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the gpio_irq peripheral.
//   - gpio_reg_e : register index decoded from Addr[5:2]
//   - byte_mask  : expands the 4-bit byte-enable into a 32-bit bit mask
//   - byte_merge : byte-masked update of a 32-bit register image
package gpio_pkg;

    typedef enum logic [3:0] {
        GPIO_DIR      = 4'd0,
        GPIO_OUT      = 4'd1,
        GPIO_IN       = 4'd2,
        GPIO_OUT_SET  = 4'd3,
        GPIO_OUT_CLR  = 4'd4,
        GPIO_OUT_TGL  = 4'd5,
        GPIO_IRQ_RISE = 4'd6,
        GPIO_IRQ_FALL = 4'd7,
        GPIO_IRQ_STAT = 4'd8
    } gpio_reg_e;

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
        logic [31:0] m;
        m = byte_mask(be);
        return (wdata & m) | (cur & ~m);
    endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// gpio_irq_if: peripheral-bus slave port (Write/Addr/WData/RData).
//   Write : 4-bit byte enables, 0000 = read/idle
//   Addr  : byte address, only [5:2] decoded by the slave
//   WData : write data
//   RData : read data from the slave
interface gpio_irq_if;
    logic [3:0]  Write;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] RData;

    modport master (output Write, Addr, WData, input  RData);
    modport slave  (input  Write, Addr, WData, output RData);
endinterface

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: per-pin input conditioning.
//   pad -> SYNC_STAGES-flop synchroniser -> [optional debounce] -> filt
//   prev flop of filt gives single-cycle rise/fall pulses.
// Ports: clk, rst (async, active-high), pad in; filt, rise, fall out.
// Optional feature: GPIO_DEBOUNCE_EN adds a DEB_CYCLES stability filter.
module gpio_in_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic filt,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_o;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
    assign sync_o = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // Count consecutive cycles where the synchronised pin disagrees with
    // the filtered value; any agreement (bounce) restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync_o == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            filt_q <= sync_o;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
    assign filt = filt_q;
`else
    localparam int unused_deb_cycles = DEB_CYCLES;
    assign filt = sync_o;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= filt;
    end

    assign rise = filt & ~prev_q;
    assign fall = ~filt & prev_q;
endmodule

// File: rtl/gpio_irq.sv
// gpio_irq: memory-mapped GPIO with per-pin direction, atomic SET/CLR/TGL,
// synchronised inputs and edge-triggered interrupt status.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : gpio_irq_if.slave (Write/Addr/WData/RData)
//   irq       : OR of IRQ_STAT, driven from flops
//   io_ports  : pads, driven with OUT where DIR=1, else released
// Parameters: N_PINS (1..32), SYNC_STAGES (>=2), MEMORY_TYPE (0 comb / 1
// registered RData), DEB_CYCLES (debounce length).
// Optional feature: define GPIO_DEBOUNCE_EN to enable per-pin debounce.
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int N_PINS      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int MEMORY_TYPE = 0,
    parameter int DEB_CYCLES  = 16
) (
    input  logic              clk,
    input  logic              rst,
    gpio_irq_if.slave         bus,
    output logic              irq,
    inout  wire  [N_PINS-1:0] io_ports
);
    logic [N_PINS-1:0] dir_q, out_q, rise_en_q, fall_en_q, stat_q;
    logic [N_PINS-1:0] filt, rise, fall;
    logic [N_PINS-1:0] wd_m, stat_set, stat_clr;
    logic [3:0]        sel;
    logic              wr;
    logic [31:0]       rdata_c;

    assign sel  = bus.Addr[5:2];
    assign wr   = |bus.Write;
    // Write data with unselected bytes zeroed, trimmed to the pin count.
    assign wd_m = N_PINS'(bus.WData & byte_mask(bus.Write));

    wire unused_addr = ^{bus.Addr[31:6], bus.Addr[1:0]};

    // Per-pin conditioning and pad drivers
    for (genvar i = 0; i < N_PINS; i++) begin : g_pin
        gpio_in_cond #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_in (
            .clk  (clk),
            .rst  (rst),
            .pad  (io_ports[i]),
            .filt (filt[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
        assign io_ports[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    // Register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (wr) begin
            case (sel)
                GPIO_DIR:      dir_q     <= N_PINS'(byte_merge(32'(dir_q), bus.WData, bus.Write));
                GPIO_OUT:      out_q     <= N_PINS'(byte_merge(32'(out_q), bus.WData, bus.Write));
                GPIO_OUT_SET:  out_q     <= out_q | wd_m;
                GPIO_OUT_CLR:  out_q     <= out_q & ~wd_m;
                GPIO_OUT_TGL:  out_q     <= out_q ^ wd_m;
                GPIO_IRQ_RISE: rise_en_q <= N_PINS'(byte_merge(32'(rise_en_q), bus.WData, bus.Write));
                GPIO_IRQ_FALL: fall_en_q <= N_PINS'(byte_merge(32'(fall_en_q), bus.WData, bus.Write));
                default: ;
            endcase
        end
    end

    // Interrupt status: a new edge event beats a same-cycle W1C so no event
    // is lost; edges on disabled pins are dropped, not held.
    assign stat_set = (rise & rise_en_q) | (fall & fall_en_q);
    assign stat_clr = (wr && sel == GPIO_IRQ_STAT) ? wd_m : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stat_q <= '0;
        else     stat_q <= (stat_q & ~stat_clr) | stat_set;
    end

    assign irq = |stat_q;

    // Read mux
    always_comb begin
        rdata_c = '0;
        case (sel)
            GPIO_DIR:      rdata_c = 32'(dir_q);
            GPIO_OUT:      rdata_c = 32'(out_q);
            GPIO_IN:       rdata_c = 32'(filt);
            GPIO_IRQ_RISE: rdata_c = 32'(rise_en_q);
            GPIO_IRQ_FALL: rdata_c = 32'(fall_en_q);
            GPIO_IRQ_STAT: rdata_c = 32'(stat_q);
            default:       rdata_c = '0;
        endcase
    end

    if (MEMORY_TYPE == 1) begin : g_rd_reg
        logic [31:0] rdata_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) rdata_q <= '0;
            else     rdata_q <= rdata_c;
        end
        assign bus.RData = rdata_q;
    end else begin : g_rd_comb
        assign bus.RData = rdata_c;
    end
endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed self-checking bench for gpio_irq (N_PINS=32,
// SYNC_STAGES=2, combinational read). Honours GPIO_DEBOUNCE_EN.
module tb_gpio_irq;
    import gpio_pkg::*;

    localparam int SS  = 2;
    localparam int DEB = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = SS + DEB;
`else
    localparam int LAT = SS;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        irq;
    logic [31:0] tb_en, tb_val;
    wire  [31:0] io_ports;
    int          n_chk  = 0;
    int          n_fail = 0;

    gpio_irq_if bus();

    for (genvar i = 0; i < 32; i++) begin : g_pad
        assign io_ports[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    gpio_irq #(
        .N_PINS      (32),
        .SYNC_STAGES (SS),
        .MEMORY_TYPE (0),
        .DEB_CYCLES  (DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .irq      (irq),
        .io_ports (io_ports)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] r, input logic [31:0] d, input logic [3:0] be = 4'hF);
        bus.Addr  = {26'h0, r, 2'b00};
        bus.WData = d;
        bus.Write = be;
        @(negedge clk);
        bus.Write = 4'h0;
    endtask

    task automatic rd(input logic [3:0] r, output logic [31:0] d);
        bus.Addr  = {26'h0, r, 2'b00};
        bus.Write = 4'h0;
        #1;
        d = bus.RData;
    endtask

    initial begin
        logic [31:0] d;
        rst       = 1'b1;
        bus.Write = 4'h0;
        bus.Addr  = '0;
        bus.WData = '0;
        tb_en     = 32'hFFFF_FFFF;   // pads pulled high during reset
        tb_val    = 32'hFFFF_FFFF;
        tick(3);
        rst = 1'b0;

        // Reset state
        rd(GPIO_DIR, d);       chk("rst_dir", d, 32'h0);
        rd(GPIO_OUT, d);       chk("rst_out", d, 32'h0);
        rd(GPIO_IRQ_RISE, d);  chk("rst_rise", d, 32'h0);
        rd(GPIO_IRQ_FALL, d);  chk("rst_fall", d, 32'h0);
        rd(GPIO_IRQ_STAT, d);  chk("rst_stat", d, 32'h0);
        rd(GPIO_IN, d);        chk("rst_in", d, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        tick(LAT - 1);
        rd(GPIO_IN, d);        chk("in_lat_early", d, 32'h0);
        tick(1);
        rd(GPIO_IN, d);        chk("in_lat", d, 32'hFFFF_FFFF);
        rd(GPIO_IRQ_STAT, d);  chk("stat_no_en", d, 32'h0);

        // Outputs on the low byte, loopback into IN
        wr(GPIO_OUT, 32'h0000_00A5);
        tb_val = 32'h5A5A_5AA5;
        wr(GPIO_DIR, 32'h0000_00FF);
        tb_en  = 32'hFFFF_FF00;
        #1;
        chk("pad_lo", {24'h0, io_ports[7:0]}, 32'h0000_00A5);
        tick(LAT + 2);
        rd(GPIO_IN, d);        chk("in_loop", d, 32'h5A5A_5AA5);
        rd(GPIO_DIR, d);       chk("dir_rb", d, 32'h0000_00FF);

        wr(GPIO_OUT_SET, 32'h0000_000F);
        rd(GPIO_OUT, d);       chk("out_set", d, 32'h0000_00AF);
        wr(GPIO_OUT_CLR, 32'h0000_00A0);
        rd(GPIO_OUT, d);       chk("out_clr", d, 32'h0000_000F);
        wr(GPIO_OUT_TGL, 32'h0000_00FF);
        rd(GPIO_OUT, d);       chk("out_tgl", d, 32'h0000_00F0);
        chk("pad_tgl", {24'h0, io_ports[7:0]}, 32'h0000_00F0);
        rd(GPIO_OUT_SET, d);   chk("wo_rd0", d, 32'h0);

        // Byte masking, unmapped register, ignored address bits
        wr(GPIO_OUT, 32'h0);
        wr(GPIO_OUT, 32'hFFFF_FFFF, 4'b0010);
        rd(GPIO_OUT, d);       chk("out_bmask", d, 32'h0000_FF00);
        wr(4'd9, 32'hFFFF_FFFF);
        rd(4'd9, d);           chk("unmapped", d, 32'h0);
        bus.Addr = 32'hFFFF_FFC4;
        #1;
        chk("addr_alias", bus.RData, 32'h0000_FF00);

        // Hand all pads back to the bench
        tb_val = 32'h0;
        tb_en  = 32'hFFFF_FFFF;
        wr(GPIO_DIR, 32'h0);
        tick(LAT + 2);
        rd(GPIO_IN, d);        chk("in_zero", d, 32'h0);

        // Edge while disabled is dropped
        tb_val[3] = 1'b1;
        tick(LAT + 2);
        wr(GPIO_IRQ_RISE, 32'h8);
        tick(2);
        rd(GPIO_IRQ_STAT, d);  chk("no_pend", d, 32'h0);
        tb_val[3] = 1'b0;
        tick(LAT + 2);
        rd(GPIO_IRQ_STAT, d);  chk("fall_ign0", d, 32'h0);

        // Rising edge timing
        tb_val[3] = 1'b1;
        tick(LAT);
        rd(GPIO_IRQ_STAT, d);  chk("stat_early", d, 32'h0);
        chk("irq_early", {31'h0, irq}, 32'h0);
        tick(1);
        rd(GPIO_IRQ_STAT, d);  chk("stat_rise", d, 32'h8);
        chk("irq_rise", {31'h0, irq}, 32'h1);

        // W1C behaviour
        wr(GPIO_IRQ_STAT, 32'h8, 4'b1110);
        rd(GPIO_IRQ_STAT, d);  chk("w1c_bmask", d, 32'h8);
        wr(GPIO_IRQ_STAT, 32'h0);
        rd(GPIO_IRQ_STAT, d);  chk("w0_noeff", d, 32'h8);
        wr(GPIO_IRQ_STAT, 32'h8);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        rd(GPIO_IRQ_STAT, d);  chk("stat_clr", d, 32'h0);

        tb_val[3] = 1'b0;
        tick(LAT + 2);
        rd(GPIO_IRQ_STAT, d);  chk("fall_ign", d, 32'h0);

        // Set and W1C on the same edge: set wins
        tb_val[3] = 1'b1;
        tick(LAT);
        wr(GPIO_IRQ_STAT, 32'h8);
        rd(GPIO_IRQ_STAT, d);  chk("set_wins", d, 32'h8);
        chk("irq_set_wins", {31'h0, irq}, 32'h1);
        wr(GPIO_IRQ_STAT, 32'h8);
        rd(GPIO_IRQ_STAT, d);  chk("clr_after", d, 32'h0);

        // Both-edge enable on pad5
        wr(GPIO_IRQ_RISE, 32'h20);
        wr(GPIO_IRQ_FALL, 32'h20);
        rd(GPIO_IRQ_FALL, d);  chk("fall_rb", d, 32'h20);
        tb_val[5] = 1'b1;
        tick(LAT + 2);
        rd(GPIO_IRQ_STAT, d);  chk("both_rise", d, 32'h20);
        wr(GPIO_IRQ_STAT, 32'h20);
        rd(GPIO_IRQ_STAT, d);  chk("both_clr", d, 32'h0);
        tb_val[5] = 1'b0;
        tick(LAT + 2);
        rd(GPIO_IRQ_STAT, d);  chk("both_fall", d, 32'h20);
        chk("irq_both", {31'h0, irq}, 32'h1);

`ifdef GPIO_DEBOUNCE_EN
        // Debounce: short glitch filtered, long pulse accepted
        wr(GPIO_IRQ_RISE, 32'h40);
        tb_val[6] = 1'b1;
        tick(10);
        tb_val[6] = 1'b0;
        tick(30);
        rd(GPIO_IN, d);        chk("deb_glitch_in", d & 32'h40, 32'h0);
        rd(GPIO_IRQ_STAT, d);  chk("deb_glitch_st", d & 32'h40, 32'h0);
        tb_val[6] = 1'b1;
        tick(20);
        rd(GPIO_IN, d);        chk("deb_pulse_in", d & 32'h40, 32'h40);
        rd(GPIO_IRQ_STAT, d);  chk("deb_pulse_st", d & 32'h40, 32'h40);
`endif

        // Asynchronous reset mid-operation
        wr(GPIO_DIR, 32'h0000_000F);
        rst = 1'b1;
        #1;
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        rd(GPIO_DIR, d);       chk("mid_rst_dir", d, 32'h0);
        rd(GPIO_IRQ_STAT, d);  chk("mid_rst_stat", d, 32'h0);
        tick(1);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
